// File: rtl/fetch_queue.sv
// fetch_queue: FIFO between fetch and decode with stall back-pressure and flush on redirect.
// Define IFQ_PERF_CNT_EN to add the bubble_cnt decode-starvation counter.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    input  logic        flush,
    output logic        if_stall,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0] bubble_cnt
`endif
);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    logic [31:0] pc_q [DEPTH];
    logic [31:0] inst_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] cnt_q, cnt_d;
    logic full, empty, push, pop;
    always_comb begin
        full     = cnt_q == FULL_CNT;
        empty    = cnt_q == '0;
        push     = in_valid & ~full & ~flush;
        pop      = ~empty & id_ready & ~flush;
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
        cnt_d    = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        if_stall = full;
        id_valid = ~empty;
        id_pc    = empty ? '0 : pc_q[rd_ptr_q];
        id_inst  = empty ? '0 : inst_q[rd_ptr_q];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
    // Storage needs no reset: empty forces the outputs to NOP.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr_q]   <= in_pc;
            inst_q[wr_ptr_q] <= in_inst;
        end
    end
`ifdef IFQ_PERF_CNT_EN
    logic [31:0] bubble_q, bubble_d;
    always_comb bubble_d = (id_ready & empty & ~&bubble_q) ? bubble_q + 32'd1 : bubble_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bubble_q <= '0;
        else     bubble_q <= bubble_d;
    end
    assign bubble_cnt = bubble_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table plus randomized traffic checked against a queue model.
module tb_fetch_queue;
    localparam int DEPTH = 2;
    logic clk = 1'b0;
    logic rst, in_valid, flush, id_ready, if_stall, id_valid;
    logic [31:0] in_pc, in_inst, id_pc, id_inst;
`ifdef IFQ_PERF_CNT_EN
    logic [31:0] bubble_cnt;
`endif
    int n_vec = 0;
    int n_err = 0;
    logic [63:0] mq [$];
    logic [31:0] m_bub = '0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .AW(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .flush(flush), .if_stall(if_stall), .id_ready(id_ready), .id_valid(id_valid),
        .id_pc(id_pc), .id_inst(id_inst)
`ifdef IFQ_PERF_CNT_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    typedef struct {
        bit v; bit [31:0] pc; bit [31:0] inst; bit fl; bit rdy;
        bit ev; bit [31:0] epc; bit [31:0] einst; bit es;
    } vec_t;
    vec_t tbl [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_bub();
`ifdef IFQ_PERF_CNT_EN
        chk("bubble_cnt", bubble_cnt, m_bub);
`endif
    endtask

    task automatic chk_model();
        logic e;
        e = mq.size() > 0;
        chk("id_valid", {31'd0, id_valid}, {31'd0, e});
        chk("id_pc", id_pc, e ? mq[0][63:32] : 32'd0);
        chk("id_inst", id_inst, e ? mq[0][31:0] : 32'd0);
        chk("if_stall", {31'd0, if_stall}, {31'd0, mq.size() == DEPTH});
        chk_bub();
    endtask

    // Applies inputs, advances the reference queue by the same cycle, and samples after the edge.
    task automatic drive(input bit v, input bit [31:0] pc, input bit [31:0] inst, input bit fl, input bit rdy);
        bit was_full, was_valid;
        in_valid = v; in_pc = pc; in_inst = inst; flush = fl; id_ready = rdy;
        was_valid = mq.size() > 0;
        was_full  = mq.size() == DEPTH;
        if (rdy && !was_valid && m_bub != 32'hFFFF_FFFF) m_bub++;
        if (fl) mq.delete();
        else begin
            if (rdy && was_valid) void'(mq.pop_front());
            if (v && !was_full) mq.push_back({pc, inst});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           v  pc          inst         fl rdy  ev epc         einst        es
        tbl[0]  = '{1, 32'h000, 32'h11, 0, 1,  1, 32'h000, 32'h11, 0};
        tbl[1]  = '{1, 32'h004, 32'h22, 0, 1,  1, 32'h004, 32'h22, 0};
        tbl[2]  = '{1, 32'h008, 32'h33, 0, 1,  1, 32'h008, 32'h33, 0};
        tbl[3]  = '{0, 32'h000, 32'h00, 0, 1,  0, 32'h000, 32'h00, 0};
        tbl[4]  = '{1, 32'h100, 32'hA1, 0, 0,  1, 32'h100, 32'hA1, 0};
        tbl[5]  = '{1, 32'h104, 32'hA2, 0, 0,  1, 32'h100, 32'hA1, 1};
        tbl[6]  = '{1, 32'h108, 32'hA3, 0, 0,  1, 32'h100, 32'hA1, 1};
        tbl[7]  = '{0, 32'h000, 32'h00, 0, 1,  1, 32'h104, 32'hA2, 0};
        tbl[8]  = '{0, 32'h000, 32'h00, 0, 1,  0, 32'h000, 32'h00, 0};
        tbl[9]  = '{1, 32'h200, 32'hB1, 0, 0,  1, 32'h200, 32'hB1, 0};
        tbl[10] = '{1, 32'h204, 32'hB2, 0, 0,  1, 32'h200, 32'hB1, 1};
        tbl[11] = '{1, 32'h208, 32'hB3, 1, 1,  0, 32'h000, 32'h00, 0};
        tbl[12] = '{1, 32'h400, 32'h44, 0, 0,  1, 32'h400, 32'h44, 0};
        tbl[13] = '{0, 32'h000, 32'h00, 0, 1,  0, 32'h000, 32'h00, 0};
        tbl[14] = '{1, 32'h500, 32'hC1, 0, 0,  1, 32'h500, 32'hC1, 0};
        tbl[15] = '{1, 32'h504, 32'hC2, 0, 0,  1, 32'h500, 32'hC1, 1};
        tbl[16] = '{1, 32'h508, 32'hC3, 0, 1,  1, 32'h504, 32'hC2, 0};
        tbl[17] = '{1, 32'h508, 32'hC3, 0, 0,  1, 32'h504, 32'hC2, 1};
        tbl[18] = '{0, 32'h000, 32'h00, 0, 1,  1, 32'h508, 32'hC3, 0};
        tbl[19] = '{0, 32'h000, 32'h00, 0, 1,  0, 32'h000, 32'h00, 0};

        rst = 1'b1; in_valid = 0; in_pc = 0; in_inst = 0; flush = 0; id_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_inst", id_inst, 32'd0);
        chk("rst_if_stall", {31'd0, if_stall}, 32'd0);
        chk_bub();

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].v, tbl[i].pc, tbl[i].inst, tbl[i].fl, tbl[i].rdy);
            chk($sformatf("t%0d_id_valid", i), {31'd0, id_valid}, {31'd0, tbl[i].ev});
            chk($sformatf("t%0d_id_pc", i), id_pc, tbl[i].epc);
            chk($sformatf("t%0d_id_inst", i), id_inst, tbl[i].einst);
            chk($sformatf("t%0d_if_stall", i), {31'd0, if_stall}, {31'd0, tbl[i].es});
            chk_bub();
        end

        // Wrap-around with irregular ready gaps
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h600 + 32'(i * 4), 32'hD0 + 32'(i), 1'b0, (i % 3) != 1);
            chk_model();
        end

        // Asynchronous reset while full, checked before the next rising edge
        drive(1'b1, 32'h700, 32'hE1, 1'b0, 1'b0);
        drive(1'b1, 32'h704, 32'hE2, 1'b0, 1'b0);
        chk("pre_rst_full", {31'd0, if_stall}, 32'd1);
        #2 rst = 1'b1;
        #1;
        mq.delete();
        m_bub = '0;
        chk("arst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("arst_if_stall", {31'd0, if_stall}, 32'd0);
        chk("arst_id_pc", id_pc, 32'd0);
        chk_bub();
        #1 rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(9, 0) < 7, 32'h1000 + 32'(i * 4), $urandom,
                  $urandom_range(19, 0) == 0, $urandom_range(9, 0) < 6);
            chk_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
